// File: rtl/spi_cmd_ctrl.sv
// Command sequencer behind the SPI slave byte receiver: turns framed header/data bytes
// into writes and reads of a 16 x 8 configuration register file.
module spi_cmd_ctrl #(
  parameter logic [7:0] DEVICE_ID = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   cmd,
  input  logic         cmd_valid,
  input  logic         ssel_active,
  output logic [7:0]   tx_byte,
  output logic         tx_load,
  output logic [127:0] cfg,
  output logic         wr_strobe,
  output logic [3:0]   wr_addr,
  output logic [7:0]   err_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t      state_r, state_next_s;
  logic [3:0]  ptr_r, ptr_next_s;
  logic [3:0]  rd_addr_s;
  logic        hdr_evt_s, err_evt_s, wr_evt_s, rd_evt_s;
  logic [7:0]  regs_r [16];
  logic [7:0]  tx_byte_r, err_count_r;
  logic        tx_load_r, wr_strobe_r;
  logic [3:0]  wr_addr_r;

  // Next-state and byte-event decode; IDLE accepts a header arriving with SSEL rising.
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    rd_addr_s    = ptr_r;
    hdr_evt_s    = 1'b0;
    err_evt_s    = 1'b0;
    wr_evt_s     = 1'b0;
    rd_evt_s     = 1'b0;
    if (!ssel_active) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_next_s = ST_HDR;
          hdr_evt_s    = cmd_valid;
        end
        ST_HDR:  hdr_evt_s = cmd_valid;
        ST_WR: begin
          if (cmd_valid) begin
            wr_evt_s   = 1'b1;
            ptr_next_s = ptr_r + 4'd1;
          end else begin
            wr_evt_s   = 1'b0;
          end
        end
        ST_RD: begin
          if (cmd_valid) begin
            rd_evt_s   = 1'b1;
            ptr_next_s = ptr_r + 4'd1;
          end else begin
            rd_evt_s   = 1'b0;
          end
        end
        ST_ERR:  state_next_s = ST_ERR;
        default: state_next_s = ST_IDLE;
      endcase
      if (hdr_evt_s) begin
        if (cmd[6:4] != 3'b000) begin
          state_next_s = ST_ERR;
          err_evt_s    = 1'b1;
        end else if (cmd[7]) begin
          state_next_s = ST_WR;
          ptr_next_s   = cmd[3:0];
        end else begin
          // First reply goes out immediately, so the pointer skips past it.
          state_next_s = ST_RD;
          rd_evt_s     = 1'b1;
          rd_addr_s    = cmd[3:0];
          ptr_next_s   = cmd[3:0] + 4'd1;
        end
      end else begin
        rd_addr_s = ptr_r;
      end
    end
  end

  // State and address pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
    end
  end

  // Register file, reply path, write strobe and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_r[0] <= DEVICE_ID;
      for (int k = 1; k < 16; k++) begin
        regs_r[k] <= 8'h00;
      end
      tx_byte_r   <= 8'h00;
      tx_load_r   <= 1'b0;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= 4'd0;
      err_count_r <= 8'h00;
    end else begin
      tx_load_r   <= rd_evt_s;
      wr_strobe_r <= wr_evt_s && (ptr_r != 4'd0);
      if (rd_evt_s) begin
        tx_byte_r <= regs_r[rd_addr_s];
      end
      // Address 0 holds the device ID and is never written.
      if (wr_evt_s && (ptr_r != 4'd0)) begin
        regs_r[ptr_r] <= cmd;
        wr_addr_r     <= ptr_r;
      end
      if (err_evt_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'd1;
      end
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_cfg
    assign cfg[8*k +: 8] = regs_r[k];
  end

  assign tx_byte   = tx_byte_r;
  assign tx_load   = tx_load_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: framed writes, reads, wrap, bad headers,
// aborts and reset; strobes are captured by a negedge monitor.
module tb_spi_cmd_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   cmd = 8'h00;
  logic         cmd_valid = 1'b0;
  logic         ssel_active = 1'b0;
  logic [7:0]   tx_byte;
  logic         tx_load;
  logic [127:0] cfg;
  logic         wr_strobe;
  logic [3:0]   wr_addr;
  logic [7:0]   err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_overlap = 0;
  logic [3:0] wr_q[$];
  logic [7:0] tx_q[$];

  spi_cmd_ctrl #(.DEVICE_ID(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
    .ssel_active(ssel_active), .tx_byte(tx_byte), .tx_load(tx_load),
    .cfg(cfg), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // One queue entry per cycle a strobe is high, so stretched pulses show up as extras.
  always @(negedge clk) begin
    if (wr_strobe) wr_q.push_back(wr_addr);
    if (tx_load) tx_q.push_back(tx_byte);
    if (wr_strobe && tx_load) n_overlap++;
  end

  function automatic logic [7:0] reg_of(input int k);
    return cfg[8*k +: 8];
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    cmd = b; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd = 8'h00;
    @(negedge clk);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    ssel_active = 1'b1;
  endtask

  task automatic frame_end();
    @(negedge clk);
    ssel_active = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic clear_q();
    wr_q.delete();
    tx_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cfg !== {120'h0, 8'hA5}) begin
      n_bad++; $display("FAIL reset_cfg got %h want %h", cfg, {120'h0, 8'hA5});
    end
    n_cmp++;
    if ({tx_load, wr_strobe, tx_byte, wr_addr, err_count} !== 22'h0) begin
      n_bad++; $display("FAIL reset_outputs got load=%b strb=%b tx=%h wa=%h err=%h want all 0",
                        tx_load, wr_strobe, tx_byte, wr_addr, err_count);
    end
  endtask

  task automatic test_reset_midframe();
    frame_begin();
    send(8'h50);
    n_cmp++;
    if (err_count !== 8'd1) begin
      n_bad++; $display("FAIL midrst_pre_err got %0d want 1", err_count);
    end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err_count !== 8'd0) begin
      n_bad++; $display("FAIL midrst_err got %0d want 0", err_count);
    end
    rst_n = 1'b1;
    frame_end();
    clear_q();
  endtask

  task automatic test_write_burst();
    clear_q();
    frame_begin();
    send(8'h83); send(8'h11); send(8'h22); send(8'h33);
    frame_end();
    n_cmp++;
    if ({reg_of(3), reg_of(4), reg_of(5)} !== 24'h112233) begin
      n_bad++; $display("FAIL wr_regs got %h %h %h want 11 22 33", reg_of(3), reg_of(4), reg_of(5));
    end
    n_cmp++;
    if (wr_q.size() != 3) begin
      n_bad++; $display("FAIL wr_strobe_count got %0d want 3", wr_q.size());
    end else if (wr_q[0] !== 4'd3 || wr_q[1] !== 4'd4 || wr_q[2] !== 4'd5) begin
      n_bad++; $display("FAIL wr_addrs got %0d %0d %0d want 3 4 5", wr_q[0], wr_q[1], wr_q[2]);
    end
    n_cmp++;
    if (tx_q.size() != 0) begin
      n_bad++; $display("FAIL wr_no_tx got %0d loads want 0", tx_q.size());
    end
  endtask

  task automatic test_wrap_readonly();
    clear_q();
    // Header presented in the same cycle SSEL rises.
    @(negedge clk);
    ssel_active = 1'b1; cmd = 8'h8F; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd = 8'h00;
    send(8'hAA); send(8'hBB);
    frame_end();
    n_cmp++;
    if (reg_of(15) !== 8'hAA) begin
      n_bad++; $display("FAIL wrap_reg15 got %h want aa", reg_of(15));
    end
    n_cmp++;
    if (reg_of(0) !== 8'hA5 || reg_of(1) !== 8'h00) begin
      n_bad++; $display("FAIL wrap_reg0_1 got %h %h want a5 00", reg_of(0), reg_of(1));
    end
    n_cmp++;
    if (wr_q.size() != 1) begin
      n_bad++; $display("FAIL wrap_strobes got %0d want 1", wr_q.size());
    end else if (wr_q[0] !== 4'd15) begin
      n_bad++; $display("FAIL wrap_addr got %0d want 15", wr_q[0]);
    end
  endtask

  task automatic test_read_burst();
    clear_q();
    frame_begin();
    send(8'h03); send(8'h00); send(8'h00);
    frame_end();
    n_cmp++;
    if (tx_q.size() != 3) begin
      n_bad++; $display("FAIL rd_loads got %0d want 3", tx_q.size());
    end else if (tx_q[0] !== 8'h11 || tx_q[1] !== 8'h22 || tx_q[2] !== 8'h33) begin
      n_bad++; $display("FAIL rd_data got %h %h %h want 11 22 33", tx_q[0], tx_q[1], tx_q[2]);
    end
    n_cmp++;
    if (wr_q.size() != 0) begin
      n_bad++; $display("FAIL rd_no_wr got %0d strobes want 0", wr_q.size());
    end
  endtask

  task automatic test_bad_header();
    logic [127:0] snap;
    snap = cfg;
    clear_q();
    frame_begin();
    send(8'h50); send(8'h77);
    frame_end();
    n_cmp++;
    if (cfg !== snap || wr_q.size() != 0 || tx_q.size() != 0) begin
      n_bad++; $display("FAIL bad_side_effects got wr=%0d tx=%0d cfg_changed=%b want 0 0 0",
                        wr_q.size(), tx_q.size(), cfg !== snap);
    end
    n_cmp++;
    if (err_count !== 8'd1) begin
      n_bad++; $display("FAIL bad_err1 got %0d want 1", err_count);
    end
    for (int i = 0; i < 256; i++) begin
      frame_begin();
      send(8'h70);
      @(negedge clk); ssel_active = 1'b0;
      @(negedge clk);
      if (i == 253) begin
        n_cmp++;
        if (err_count !== 8'd255) begin
          n_bad++; $display("FAIL bad_err255 got %0d want 255", err_count);
        end
      end
    end
    n_cmp++;
    if (err_count !== 8'd255) begin
      n_bad++; $display("FAIL bad_err_sat got %0d want 255", err_count);
    end
  endtask

  task automatic test_frame_abort();
    clear_q();
    frame_begin();
    send(8'h84);
    @(negedge clk);
    ssel_active = 1'b0; cmd = 8'h99; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd = 8'h00;
    @(negedge clk);
    n_cmp++;
    if (reg_of(4) !== 8'h22 || wr_q.size() != 0) begin
      n_bad++; $display("FAIL abort_drop got reg4=%h strobes=%0d want 22 0", reg_of(4), wr_q.size());
    end
    frame_begin();
    send(8'h04); send(8'h00);
    frame_end();
    n_cmp++;
    if (tx_q.size() != 2) begin
      n_bad++; $display("FAIL abort_next_loads got %0d want 2", tx_q.size());
    end else if (tx_q[0] !== 8'h22 || tx_q[1] !== 8'h33) begin
      n_bad++; $display("FAIL abort_next_data got %h %h want 22 33", tx_q[0], tx_q[1]);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_write_burst();
    test_wrap_readonly();
    test_read_burst();
    test_bad_header();
    test_frame_abort();
    n_cmp++;
    if (n_overlap != 0) begin
      n_bad++; $display("FAIL strobe_overlap got %0d cycles want 0", n_overlap);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer behind the SPI slave byte receiver. It turns the stream of received bytes (one `cmd`/`cmd_valid` pulse per byte) into framed register transactions. A frame is bounded by SSEL. The block owns a 16 x 8 configuration register file that the rest of the FPGA reads. On reads it supplies reply bytes to the slave's transmit buffer through a load strobe.

## Interface
Parameters:
- `DEVICE_ID`, default 8'hA5: read-only contents of register 0.

Ports (clock and reset first):
- `clk`  input  1: system clock; all logic is on its rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `cmd`  input  8: received byte from the SPI slave; valid only while `cmd_valid`=1.
- `cmd_valid`  input  1: single-cycle pulse, one per received byte.
- `ssel_active`  input  1: 1 while a frame is in progress (synchronized SSEL, already inverted).
- `tx_byte`  output  8: next reply byte for the slave transmit buffer.
- `tx_load`  output  1: one-cycle pulse; `tx_byte` is valid in the same cycle.
- `cfg`  output  128: register file, flattened; reg k occupies `cfg[8k+7:8k]`.
- `wr_strobe`  output  1: one-cycle pulse in the cycle a writable register changes.
- `wr_addr`  output  4: address of the write; valid with `wr_strobe`.
- `err_count`  output  8: saturating count of rejected headers.

## Operation
- Header byte is the first `cmd_valid` of a frame:
  - bit7 = 1 selects write, 0 selects read.
  - bits[6:4] must be 000; any other value is an error.
  - bits[3:0] are the start address.
- States:
  - IDLE: waits for `ssel_active`=1, then goes to HDR.
  - HDR: a valid header goes to WR or RD and loads the address pointer. A bad header goes to ERR and increments `err_count`, saturating at 255.
  - WR: each byte is written to `reg[ptr]`, then `ptr` increments.
  - RD: each byte is a dummy; the reply for `reg[ptr]` is loaded, then `ptr` increments.
  - ERR: bytes are discarded.
- Frame end: `ssel_active`=0 in any state goes to IDLE on the next edge.
  - A byte arriving in that same cycle is dropped.
  - A partial transaction is not rolled back; registers already written stay written.
- Pointer is 4 bits and wraps 15 -> 0. There is no length limit.
- Register 0 always reads `DEVICE_ID`.
  - A write to address 0 is ignored: no `wr_strobe`, but `ptr` still advances.
- Registers 1..15 reset to 0.

## Timing
- Reset values: all registers 1..15 = 0, `tx_byte`=0, `tx_load`=0, `wr_strobe`=0, `wr_addr`=0, `err_count`=0, state = IDLE, `ptr`=0.
- Reset is asserted asynchronously and released synchronously. Asserting it mid-frame aborts the frame.
- Write latency: for `cmd_valid` at edge N (state WR), `cfg` changes at N+1 and `wr_strobe`/`wr_addr` are asserted during cycle N+1.
- Read, header accepted at edge N:
  - `tx_byte` = `reg[addr]` and `tx_load`=1 during cycle N+1.
  - Each later `cmd_valid` at edge M gives the next byte with `tx_load` during M+1.
  - The first reply therefore precedes the first dummy byte, so the master sees data from byte 2 of the frame onward.
- `tx_load` and `wr_strobe` are never asserted together and are never asserted for more than one cycle.
- A header on the same cycle as `ssel_active` rising is legal: the transition IDLE -> HDR happens before the byte is accepted, so the byte must be held. Implementation: IDLE treats `cmd_valid` with `ssel_active`=1 as a header.

## Test plan
- Reset: check `cfg` = {15 x 8'h00, 8'hA5} and all strobes 0. Pulse `rst_n` low mid-frame -> state returns to IDLE and `err_count` = 0.
- Write burst: frame 8'h83, 11, 22, 33 -> regs 3,4,5 = 11,22,33; three `wr_strobe` pulses with `wr_addr` 3,4,5.
- Wrap and read-only: write frame 8'h8F, AA, BB -> reg15 = AA and reg0 still A5. Exactly one `wr_strobe` (address 15).
- Read burst: after the write burst, frame 8'h03, xx, xx -> `tx_load` pulses carry 11, 22, 33.
- Bad header: frame 8'h50, 77 -> no register change and no `tx_load`; `err_count` = 1. 256 more bad frames -> `err_count` saturates at 255.
- Frame abort: `ssel_active` drops in the same cycle as the data byte of frame 8'h84, 99 -> byte dropped, reg4 unchanged. The next frame parses its header normally.
